// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state codes,
// the default operand width and the counter-width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter needs at least one bit, even for a single-bit adder.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// Single-bit full adder, the shared arithmetic element of the serial adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fulladder time-shared over WIDTH cycles, LSB first.
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | one bit step per clock
//   DONE    | result valid, done pulse
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_accept;
    logic             w_fa_sum;
    logic             w_fa_cout;

    fulladder u_fulladder (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next = start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_next = (r_cnt == LAST) ? ST_DONE : ST_RUN;
            ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Start is honoured only outside RUN, so operands in flight never change.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_sum[r_cnt] <= w_fa_sum;
            r_carry      <= w_fa_cout;
            r_a          <= r_a >> 1;
            r_b          <= r_b >> 1;
            if (r_cnt == LAST) begin
                r_cout <= w_fa_cout;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that time-shares one `fulladder` instance to add two WIDTH-bit operands, one bit per clock, LSB first. The block latches the operands on a start handshake, drives the full adder's `a`/`b`/`cin` from shift registers and a registered carry, and collects the sum bits into a result register. It sits above the existing single-bit `fulladder` and is the first sequential datapath block built on it.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range 1..32.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request to begin an addition; sampled on the rising edge.
- `a`  input  WIDTH  operand A; latched on the accepting edge.
- `b`  input  WIDTH  operand B; latched on the accepting edge.
- `cin`  input  1  carry-in to bit 0; latched on the accepting edge.
- `busy`  output  1  high while the state is RUN.
- `done`  output  1  one-cycle pulse; high only in state DONE.
- `sum`  output  WIDTH  result register.
- `cout`  output  1  carry out of bit WIDTH-1.

## Operation
- Reset: all outputs clear to 0 (`busy`=0, `done`=0, `sum`=0, `cout`=0). Internal state is IDLE, bit counter is 0, and the operand shift registers and carry register are 0. Reset takes effect immediately, including in the middle of RUN. No partial result is kept.
- States:
  - IDLE: waits for `start`.
  - RUN: one bit is processed per cycle.
  - DONE: the result is valid and `done`=1.
- Transitions:
  - IDLE and `start`=1 -> RUN. On this edge: load the A and B shift registers, load the carry register with `cin`, clear the counter, and clear `sum` and `cout`.
  - IDLE and `start`=0 -> IDLE.
  - RUN with counter < WIDTH-1 -> RUN, and the counter increments.
  - RUN with counter = WIDTH-1 -> DONE.
  - DONE and `start`=1 -> RUN. This is a back-to-back start, with the same loading as from IDLE.
  - DONE and `start`=0 -> IDLE.
- `start` is ignored in RUN. It is not queued, and the operands in flight are unchanged.
- Each RUN edge performs one bit step:
  - The `fulladder` inputs are the A shift-register LSB, the B shift-register LSB, and the carry register.
  - `sum` bit [counter] takes `fulladder.sum`.
  - The carry register takes `fulladder.cout`.
  - Both shift registers shift right by one.
- On the last RUN edge (counter = WIDTH-1), `cout` also takes `fulladder.cout`.
- `sum` and `cout` hold their values through DONE and IDLE until the next accepted start.
- Arithmetic: {`cout`, `sum`} = `a` + `b` + `cin`, computed modulo 2^(WIDTH+1) with no overflow flag beyond `cout`.
- Counter width: $clog2(WIDTH), with a minimum of 1 bit. With WIDTH=1, RUN lasts exactly one cycle.
- Input changes on `a`, `b` or `cin` after the accepting edge have no effect on the result.

## Timing
- Let edge E0 be the edge on which start is accepted.
  - After E0: `busy`=1.
  - Edges E1..EWIDTH are the RUN steps for bits 0..WIDTH-1.
  - After EWIDTH: `busy`=0 and `done`=1, with `sum`/`cout` final.
- Latency: `done` rises WIDTH cycles after the accepting edge.
- `done` stays high for exactly one cycle, unless a back-to-back start arrives. In that case `done`=1 in the DONE cycle and `busy`=1 on the next cycle.
- Throughput: one addition every WIDTH+1 cycles when restarted from DONE.
- `busy` and `done` are never high in the same cycle. All outputs are registered; no combinational path runs from inputs to outputs.

## Structure
- Shared package/header `serial_adder_pkg`:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2; the code 2'd3 recovers to IDLE);
  - the default WIDTH constant.
- Exactly one sub-module: the existing `fulladder`, instantiated once as `u_fulladder`.
- Everything else is local: FSM, counter, shift registers and carry register.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert `rst_n`=0 with junk on the inputs -> `busy`=0, `done`=0, `sum`=0x00, `cout`=0. Release reset, hold `start`=0 for 20 cycles -> nothing changes.
- Basic add: `a`=0x3C, `b`=0x42, `cin`=0, one-cycle `start` -> `busy` high for 8 cycles. `done` pulses on the 8th cycle after the accepting edge with `sum`=0x7E, `cout`=0. The result is still held 5 cycles later.
- Carry chain: `a`=0xFF, `b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1. Then `a`=0xA5, `b`=0x5A, `cin`=1 -> `sum`=0x00, `cout`=1.
- Ignored start and stable operands:
  - Start 0x10+0x20+0. At RUN cycle 3, pulse `start` with `a`=0xFF, `b`=0xFF.
  - Required: the first `done` gives `sum`=0x30, `cout`=0. No second `done` follows, and the FSM returns to IDLE.
- Back-to-back: hold `start`=1 with 0x01+0x01+0 on the first pass. In the DONE cycle, change to 0x80+0x80+0.
  - Required: first result `sum`=0x02, `cout`=0.
  - Required: a second `done` exactly 9 cycles after the first, with `sum`=0x00, `cout`=1.
- Reset mid-operation: drop `rst_n` asynchronously (between clock edges) at RUN cycle 5.
  - Required: the outputs clear immediately.
  - Required: a following 0x0F+0xF0+1 gives `sum`=0x00, `cout`=1 with normal latency.
